pc_pipe_unit: RTL

//  Parametrised successor to the stage-1 program counter. Holds fetch PC, issues

---
 rtl/pc_pipe_unit_pkg.sv | 16 +
 rtl/pc_pipe_unit_if.sv | 22 ++
 rtl/pc_pipe_unit_stage_reg.sv | 36 +++
 rtl/pc_pipe_unit.sv | 101 ++++++++++
 4 files changed

// File: rtl/pc_pipe_unit_pkg.sv
// Shared constants and next-PC select encoding for the stage-1 fetch PC unit.
// Optional feature macro used by pc_pipe_unit: PC_MISALIGN_TRAP_EN.
package pc_pkg;

   localparam int unsigned     PC_XLEN     = 32;
   localparam logic [31:0]     PC_RESET_PC = 32'h0000_2000;
   localparam int unsigned     PC_INC      = 4;

   typedef enum logic [1:0] {
      SEL_RESET,
      SEL_REDIRECT,
      SEL_HOLD,
      SEL_SEQ
   } pc_sel_e;

endpackage

// File: rtl/pc_pipe_unit_if.sv
// Instruction-memory request channel: valid/ready handshake plus fetch address.
interface pc_pipe_unit_if #(
   parameter int unsigned XLEN = 32
);

   logic            imem_req_valid;
   logic            imem_req_ready;
   logic [XLEN-1:0] imem_req_addr;

   modport master (
      output imem_req_valid,
      output imem_req_addr,
      input  imem_req_ready
   );

   modport slave (
      input  imem_req_valid,
      input  imem_req_addr,
      output imem_req_ready
   );

endinterface

// File: rtl/pc_pipe_unit_stage_reg.sv
// One tracked pipeline stage: PC plus valid bit with reset, flush, stall and load.
module pc_stage_reg
   import pc_pkg::*;
#(
   parameter int unsigned XLEN = PC_XLEN
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            i_flush,
   input  logic            i_stall,
   input  logic [XLEN-1:0] i_pc,
   input  logic            i_valid,
   output logic [XLEN-1:0] o_pc,
   output logic            o_valid
);

   logic [XLEN-1:0] r_pc;
   logic            r_valid;

   // A flush only kills the valid bit; the PC is left as-is for debug visibility.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_pc    <= '0;
         r_valid <= 1'b0;
      end else if (i_flush) begin
         r_valid <= 1'b0;
      end else if (!i_stall) begin
         r_pc    <= i_pc;
         r_valid <= i_valid;
      end
   end

   assign o_pc    = r_pc;
   assign o_valid = r_valid;

endmodule

// File: rtl/pc_pipe_unit.sv
// Stage-1 fetch PC with imem handshake, prioritised redirect and DEPTH tracked stages.
// Optional feature macro: PC_MISALIGN_TRAP_EN (align redirect targets, flag misalignment).
module pc_pipe_unit
   import pc_pkg::*;
#(
   parameter int unsigned     XLEN     = PC_XLEN,
   parameter logic [XLEN-1:0] RESET_PC = XLEN'(PC_RESET_PC),
   parameter int unsigned     INC      = PC_INC,
   parameter int unsigned     DEPTH    = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  stall,
   input  logic                  redirect,
   input  logic [XLEN-1:0]       redirect_target,
   pc_pipe_unit_if.master        imem,
   output logic [DEPTH*XLEN-1:0] stage_pc,
   output logic [DEPTH-1:0]      stage_valid,
   output logic                  misaligned
);

   logic [XLEN-1:0] r_pc_f;
   logic            r_run;
   logic            w_req_valid;
   logic            w_fire;
   logic [XLEN-1:0] w_target;
   pc_sel_e         w_sel;

   assign w_req_valid         = r_run & ~stall;
   assign w_fire              = w_req_valid & imem.imem_req_ready;
   assign imem.imem_req_valid = w_req_valid;
   assign imem.imem_req_addr  = r_pc_f;

`ifdef PC_MISALIGN_TRAP_EN
   logic r_misaligned;

   assign w_target = {redirect_target[XLEN-1:2], 2'b00};

   always_ff @(posedge clk) begin
      if (reset) r_misaligned <= 1'b0;
      else       r_misaligned <= redirect & (|redirect_target[1:0]);
   end

   assign misaligned = r_misaligned;
`else
   assign w_target   = redirect_target;
   assign misaligned = 1'b0;
`endif

   always_comb begin
      w_sel = SEL_HOLD;
      if (reset)         w_sel = SEL_RESET;
      else if (redirect) w_sel = SEL_REDIRECT;
      else if (stall)    w_sel = SEL_HOLD;
      else if (w_fire)   w_sel = SEL_SEQ;
   end

   always_ff @(posedge clk) begin
      r_run <= ~reset;
      case (w_sel)
         SEL_RESET:    r_pc_f <= RESET_PC;
         SEL_REDIRECT: r_pc_f <= w_target;
         SEL_SEQ:      r_pc_f <= r_pc_f + XLEN'(INC);
         default:      r_pc_f <= r_pc_f;
      endcase
   end

   logic [XLEN-1:0] w_q_pc    [DEPTH];
   logic            w_q_valid [DEPTH];

   // Stage 0 captures pc_f every advancing cycle; only a fired request makes it valid.
   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
      logic [XLEN-1:0] w_d_pc;
      logic            w_d_valid;

      if (gi == 0) begin : g_head
         assign w_d_pc    = r_pc_f;
         assign w_d_valid = w_fire;
      end else begin : g_tail
         assign w_d_pc    = w_q_pc[gi-1];
         assign w_d_valid = w_q_valid[gi-1];
      end

      pc_stage_reg #(
         .XLEN (XLEN)
      ) u_stage (
         .clk     (clk),
         .reset   (reset),
         .i_flush (redirect),
         .i_stall (stall),
         .i_pc    (w_d_pc),
         .i_valid (w_d_valid),
         .o_pc    (w_q_pc[gi]),
         .o_valid (w_q_valid[gi])
      );

      assign stage_pc[gi*XLEN +: XLEN] = w_q_pc[gi];
      assign stage_valid[gi]           = w_q_valid[gi];
   end

endmodule
